// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH bits with valid/ready on both sides and bubble collapse.
// Define DFF_PIPE_COUNT_EN to add the registered occupancy port `count`.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clearb,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready
`ifdef DFF_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   count
`endif
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d  [DEPTH];

  // A stage may load when it is empty or when its successor moves on
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !vld_p[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = !vld_p[i] | adv[i+1];
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = vld_p[i-1];
      src_d[i] = data_p[i-1];
    end
  end

  assign in_ready  = adv[0] & clearb;
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];

  // Stage registers: data only loads when the upstream word is valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
    end else if (!clearb) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          vld_p[i] <= src_v[i];
          if (src_v[i]) data_p[i] <= src_d[i];
        end
      end
    end
  end

`ifdef DFF_PIPE_COUNT_EN
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Occupancy tracks the popcount of vld_p through the same transfers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!clearb) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed and random bench for dff_pipe: one 8x3 instance plus 16x1 and 16x5 instances under random traffic.
module tb_dff_pipe;

  logic        clock;
  logic        reset;
  logic        clearb;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;

  logic        r1_in_valid, r1_in_ready, r1_out_valid, r1_out_ready;
  logic [15:0] r1_in_data, r1_out_data;
  logic        r5_in_valid, r5_in_ready, r5_out_valid, r5_out_ready;
  logic [15:0] r5_in_data, r5_out_data;

`ifdef DFF_PIPE_COUNT_EN
  logic [1:0]  count;
  logic [0:0]  r1_count;
  logic [2:0]  r5_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] q1 [$];
  logic [15:0] q5 [$];

  dff_pipe #(.WIDTH(8), .DEPTH(3)) u_dut (
    .clock(clock), .reset(reset), .clearb(clearb),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef DFF_PIPE_COUNT_EN
    , .count(count)
`endif
  );

  dff_pipe #(.WIDTH(16), .DEPTH(1)) u_r1 (
    .clock(clock), .reset(reset), .clearb(clearb),
    .in_valid(r1_in_valid), .in_data(r1_in_data), .in_ready(r1_in_ready),
    .out_valid(r1_out_valid), .out_data(r1_out_data), .out_ready(r1_out_ready)
`ifdef DFF_PIPE_COUNT_EN
    , .count(r1_count)
`endif
  );

  dff_pipe #(.WIDTH(16), .DEPTH(5)) u_r5 (
    .clock(clock), .reset(reset), .clearb(clearb),
    .in_valid(r5_in_valid), .in_data(r5_in_data), .in_ready(r5_in_ready),
    .out_valid(r5_out_valid), .out_data(r5_out_data), .out_ready(r5_out_ready)
`ifdef DFF_PIPE_COUNT_EN
    , .count(r5_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clearb = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    r1_in_valid = 1'b0; r1_in_data = '0; r1_out_ready = 1'b0;
    r5_in_valid = 1'b0; r5_in_data = '0; r5_out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef DFF_PIPE_COUNT_EN
    check("rst_count", count, 0);
`endif
    @(negedge clock) reset = 1'b0;

    // Reset and fill
    @(negedge clock) out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    check("fill_in_ready", in_ready, 1);
    @(negedge clock) in_data = 8'h22;
    check("fill_lat1", out_valid, 0);
    @(negedge clock) in_data = 8'h33;
    check("fill_lat2", out_valid, 0);
    @(negedge clock) in_valid = 1'b0;
    check("fill_v11", out_valid, 1);
    check("fill_d11", out_data, 8'h11);
    @(negedge clock) check("fill_d22", out_data, 8'h22);
    @(negedge clock) check("fill_d33", out_data, 8'h33);
    @(negedge clock) check("fill_empty", out_valid, 0);
    out_ready = 1'b0;

    // Stall and backpressure
    in_valid = 1'b1; in_data = 8'hA1;
    @(negedge clock) in_data = 8'hA2;
    @(negedge clock) in_data = 8'hA3;
    @(negedge clock) in_data = 8'hA4;
    check("stall_in_ready", in_ready, 0);
    check("stall_head", out_data, 8'hA1);
`ifdef DFF_PIPE_COUNT_EN
    check("stall_count", count, 3);
`endif
    @(negedge clock) check("stall_hold_ready", in_ready, 0);
    check("stall_hold_head", out_data, 8'hA1);
    out_ready = 1'b1;
    #1 check("stall_release_ready", in_ready, 1);
    @(negedge clock) in_valid = 1'b0;
    check("stall_dA2", out_data, 8'hA2);
    @(negedge clock) check("stall_dA3", out_data, 8'hA3);
    @(negedge clock) check("stall_dA4", out_data, 8'hA4);
    @(negedge clock) check("stall_empty", out_valid, 0);
    out_ready = 1'b0;

    // Bubble collapse
    in_valid = 1'b1; in_data = 8'h05;
    @(negedge clock) in_valid = 1'b0;
    @(negedge clock) in_valid = 1'b1; in_data = 8'h06;
    @(negedge clock) in_valid = 1'b0;
    @(negedge clock);
    check("bub_in_ready", in_ready, 1);
    check("bub_head", out_data, 8'h05);
`ifdef DFF_PIPE_COUNT_EN
    check("bub_count2", count, 2);
`endif
    in_valid = 1'b1; in_data = 8'h07;
    @(negedge clock) in_valid = 1'b0;
    check("bub_full_ready", in_ready, 0);
`ifdef DFF_PIPE_COUNT_EN
    check("bub_count3", count, 3);
`endif

    // Sync clear with the pipeline full
    clearb = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    #1 check("clr_in_ready", in_ready, 0);
    @(negedge clock) clearb = 1'b1; in_valid = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_out_data", out_data, 0);
`ifdef DFF_PIPE_COUNT_EN
    check("clr_count", count, 0);
`endif
    @(negedge clock) check("clr_no_accept", out_valid, 0);

    // Async reset mid-stream
    in_valid = 1'b1; in_data = 8'hB1;
    @(negedge clock) in_data = 8'hB2;
    @(negedge clock) in_data = 8'hB3;
    @(negedge clock) in_valid = 1'b0;
    check("arst_full", out_data, 8'hB1);
    #2 reset = 1'b1;
    #1 check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    #1 reset = 1'b0; in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b1;
    @(negedge clock) in_valid = 1'b0;
    check("arst_lat1", out_valid, 0);
    @(negedge clock) check("arst_lat2", out_valid, 0);
    @(negedge clock) check("arst_lat3_v", out_valid, 1);
    check("arst_lat3_d", out_data, 8'hC3);
    @(negedge clock) out_ready = 1'b0;

    // Random traffic with a final drain phase
    for (int n = 0; n < 10020; n++) begin
      @(negedge clock);
      if (n < 10000) begin
        r1_in_valid  = 1'($urandom_range(0, 1));
        r1_out_ready = 1'($urandom_range(0, 1));
        r5_in_valid  = 1'($urandom_range(0, 1));
        r5_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        r1_in_valid = 1'b0; r1_out_ready = 1'b1;
        r5_in_valid = 1'b0; r5_out_ready = 1'b1;
      end
      r1_in_data = 16'($urandom);
      r5_in_data = 16'($urandom);
      #2;
`ifdef DFF_PIPE_COUNT_EN
      check("r1_count", 32'(r1_count), q1.size());
      check("r5_count", 32'(r5_count), q5.size());
`endif
      if (r1_out_valid && r1_out_ready) begin
        if (q1.size() == 0) check("r1_unexpected", 1, 0);
        else check("r1_data", r1_out_data, q1.pop_front());
      end
      if (r1_in_valid && r1_in_ready) q1.push_back(r1_in_data);
      if (r5_out_valid && r5_out_ready) begin
        if (q5.size() == 0) check("r5_unexpected", 1, 0);
        else check("r5_data", r5_out_data, q5.pop_front());
      end
      if (r5_in_valid && r5_in_ready) q5.push_back(r5_in_data);
    end
    check("r1_drained", q1.size(), 0);
    check("r5_drained", q5.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
